// File: rtl/alu_pkg.sv
// Shared op-code encodings and handshake FSM states for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_mc_divu.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH steps.
module divu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted, trial;

  // quotient/remainder present the values after the current step, so on the
  // done cycle they are the final results and the caller can register them.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      remainder = trial[WIDTH-1:0];
      quotient  = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      remainder = shifted[WIDTH-1:0];
      quotient  = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      rem_q   <= '0;
      quot_q  <= dividend;
      dvsr_q  <= divisor;
      count_q <= CNT_W'(WIDTH - 1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= remainder;
      quot_q <= quotient;
      if (count_q == '0) busy_q <= 1'b0;
      else               count_q <= count_q - 1'b1;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (count_q == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake, registered results, iterative DIVU.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem_out,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t           state, state_next;
  logic             accept, div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;
  logic [WIDTH-1:0] res, rem_res, diff;
  logic             res_zero, res_dbz, slt_ovf;

  assign in_ready  = (state != ST_DIV);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (op == OP_DIVU) && (in_b != '0);

  divu_iter #(.WIDTH(WIDTH)) u_divu (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (in_a),
    .divisor   (in_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // SLT uses the sign of the true difference: raw MSB corrected by overflow.
  assign diff    = in_a - in_b;
  assign slt_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);

  always_comb begin
    res      = '0;
    rem_res  = '0;
    res_dbz  = 1'b0;
    case (op)
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_ADD:  res = in_a + in_b;
      OP_SLL:  res = in_a << in_b[SHAMT_W-1:0];
      OP_DIVU: begin
        res     = '1;
        rem_res = in_a;
        res_dbz = 1'b1;
      end
      OP_BNE:  res = diff;
      OP_SUB:  res = diff;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ slt_ovf};
      default: res = '0;
    endcase
    if (res_dbz)           res_zero = 1'b0;
    else if (op == OP_BNE) res_zero = (res != '0);
    else                   res_zero = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (div_start) state_next = ST_DIV;
      ST_DIV:  if (div_done)  state_next = ST_DONE;
      ST_DONE: state_next = div_start ? ST_DIV : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out         <= '0;
      rem_out     <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == ST_DIV && div_done) begin
        out_valid <= 1'b1;
        out       <= div_quot;
        rem_out   <= div_rem;
        zero      <= (div_quot == '0);
      end else if (accept && !div_start) begin
        out_valid   <= 1'b1;
        out         <= res;
        rem_out     <= rem_res;
        zero        <= res_zero;
        div_by_zero <= res_dbz;
      end
    end
  end

endmodule
